// File: rtl/axis_pixels_upsizer_pkg.sv
// Shared definitions for the pixel-stream width upsizer.
//   DEF_S_WIDTH / DEF_RATIO : default narrow width and packing ratio
//   M_WIDTH / KEEP_W        : resulting wide tdata / tkeep widths
//   lane_t / lane_keep_t    : one narrow lane of data / byte enables
//   idx_width()             : width of the lane counter for a given ratio
package axis_pixels_upsizer_pkg;

    localparam int DEF_S_WIDTH = 32;
    localparam int DEF_RATIO   = 4;
    localparam int M_WIDTH     = DEF_S_WIDTH * DEF_RATIO;
    localparam int KEEP_W      = M_WIDTH / 8;

    typedef logic [DEF_S_WIDTH-1:0]   lane_t;
    typedef logic [DEF_S_WIDTH/8-1:0] lane_keep_t;

    // A ratio of 1 still needs a one-bit counter so the port widths stay legal.
    function automatic int idx_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/axis_pixels_upsizer.sv
// AXI-Stream width upsizer feeding dnn_engine's pixel input.
// Packs RATIO consecutive narrow beats into one wide beat (lane 0 = LSBs),
// flushing a partial wide beat early on s_axis_tlast. Byte enables travel
// with their lane unchanged; unused upper lanes carry data 0 / keep 0.
//
// Ports:
//   aclk, areset        clock, synchronous active-high reset
//   s_axis_*            narrow input stream (tvalid/tready/tdata/tkeep/tlast)
//   m_axis_*            registered wide output stream
module axis_pixels_upsizer
    import axis_pixels_upsizer_pkg::*;
#(
    parameter int S_WIDTH = DEF_S_WIDTH,
    parameter int RATIO   = DEF_RATIO
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic [S_WIDTH-1:0]          s_axis_tdata,
    input  logic [S_WIDTH/8-1:0]        s_axis_tkeep,
    input  logic                        s_axis_tlast,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [S_WIDTH*RATIO-1:0]    m_axis_tdata,
    output logic [S_WIDTH*RATIO/8-1:0]  m_axis_tkeep,
    output logic                        m_axis_tlast
);

    localparam int IDX_W      = idx_width(RATIO);
    localparam int IN_KEEP_W  = S_WIDTH / 8;
    localparam int OUT_W      = S_WIDTH * RATIO;
    localparam int OUT_KEEP_W = OUT_W / 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    logic [IDX_W-1:0]      idx;
    logic [OUT_W-1:0]      acc_data;
    logic [OUT_KEEP_W-1:0] acc_keep;
    logic                  s_accept;
    logic                  complete;
    logic [OUT_W-1:0]      pack_data;
    logic [OUT_KEEP_W-1:0] pack_keep;

    // Intake stalls only when a wide beat is parked and not being taken, so
    // a completion can overwrite the output register in the same cycle it drains.
    assign s_axis_tready = !areset && (!m_axis_tvalid || m_axis_tready);
    assign s_accept      = s_axis_tvalid && s_axis_tready;
    assign complete      = s_accept && ((idx == LAST_IDX) || s_axis_tlast);

    // Wide word as it would look if the current beat completed it: stored
    // lanes below idx, the live beat in lane idx, zeros above.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; otherwise
        // the unassigned cases would infer latches.
        pack_data = '0;
        pack_keep = '0;
        for (int l = 0; l < RATIO; l++) begin
            if (IDX_W'(l) < idx) begin
                pack_data[l*S_WIDTH +: S_WIDTH]     = acc_data[l*S_WIDTH +: S_WIDTH];
                pack_keep[l*IN_KEEP_W +: IN_KEEP_W] = acc_keep[l*IN_KEEP_W +: IN_KEEP_W];
            end else if (IDX_W'(l) == idx) begin
                pack_data[l*S_WIDTH +: S_WIDTH]     = s_axis_tdata;
                pack_keep[l*IN_KEEP_W +: IN_KEEP_W] = s_axis_tkeep;
            end
        end
    end

    // Lane counter and accumulator.
    always_ff @(posedge aclk) begin
        // NOTE: non-blocking assignments keep every register updating from
        // pre-edge values, so ordering inside the block does not matter.
        if (areset) begin
            idx      <= '0;
            acc_data <= '0;
            acc_keep <= '0;
        end else if (complete) begin
            idx      <= '0;
            acc_keep <= '0;
        end else if (s_accept) begin
            idx <= idx + IDX_W'(1);
            for (int l = 0; l < RATIO; l++) begin
                if (IDX_W'(l) == idx) begin
                    acc_data[l*S_WIDTH +: S_WIDTH]     <= s_axis_tdata;
                    acc_keep[l*IN_KEEP_W +: IN_KEEP_W] <= s_axis_tkeep;
                end
            end
        end
    end

    // Registered wide output; holds steady while stalled because neither
    // branch fires when tvalid is high and tready is low.
    always_ff @(posedge aclk) begin
        if (areset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (complete) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= pack_data;
            m_axis_tkeep  <= pack_keep;
            m_axis_tlast  <= s_axis_tlast;
        end else if (m_axis_tvalid && m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axis_pixels_upsizer.sv
// Directed and randomised bench for axis_pixels_upsizer (S_WIDTH=32, RATIO=4).
module tb_axis_pixels_upsizer;
    import axis_pixels_upsizer_pkg::*;

    typedef struct packed {
        logic [M_WIDTH-1:0] d;
        logic [KEEP_W-1:0]  k;
        logic               l;
    } wide_t;

    logic               aclk = 1'b0;
    logic               areset = 1'b1;
    logic               s_axis_tvalid = 1'b0;
    logic               s_axis_tready;
    lane_t              s_axis_tdata = '0;
    lane_keep_t         s_axis_tkeep = '0;
    logic               s_axis_tlast = 1'b0;
    logic               m_axis_tvalid;
    logic               m_axis_tready = 1'b1;
    logic [M_WIDTH-1:0] m_axis_tdata;
    logic [KEEP_W-1:0]  m_axis_tkeep;
    logic               m_axis_tlast;

    int    total = 0;
    int    bad = 0;
    wide_t got[$];
    logic  prev_stall = 1'b0;
    wide_t prev_beat;
    logic  rnd_on = 1'b0;

    always #5 aclk = ~aclk;

    axis_pixels_upsizer dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast)
    );

    // Inputs change just after posedge, so the negedge sees what the next
    // posedge will see: record wide handshakes and check stall stability.
    always @(negedge aclk) begin
        if (!areset && prev_stall) begin
            total++;
            if (!m_axis_tvalid || m_axis_tdata !== prev_beat.d ||
                m_axis_tkeep !== prev_beat.k || m_axis_tlast !== prev_beat.l) begin
                bad++;
                $display("FAIL stability: got v=%b d=%h k=%h l=%b want v=1 d=%h k=%h l=%b",
                         m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
                         prev_beat.d, prev_beat.k, prev_beat.l);
            end
        end
        prev_stall = !areset && m_axis_tvalid && !m_axis_tready;
        prev_beat  = '{d: m_axis_tdata, k: m_axis_tkeep, l: m_axis_tlast};
        if (!areset && m_axis_tvalid && m_axis_tready)
            got.push_back('{d: m_axis_tdata, k: m_axis_tkeep, l: m_axis_tlast});
    end

    // Present one narrow beat and return just after the edge that accepts it.
    task automatic send(input lane_t d, input lane_keep_t k, input logic l, output int waits);
        waits = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        do begin
            @(negedge aclk);
            waits++;
        end while (!s_axis_tready && waits < 200);
        total++;
        if (!s_axis_tready) begin
            bad++;
            $display("FAIL send_timeout: beat %h not accepted after %0d cycles, want accept", d, waits);
        end
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic test_reset;
        areset = 1'b1;
        m_axis_tready = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        total++;
        if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, s_axis_tready} !== '0) begin
            bad++;
            $display("FAIL reset_state: v=%b d=%h k=%h l=%b rdy=%b want all 0",
                     m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, s_axis_tready);
        end
        @(posedge aclk);
        #1;
        areset = 1'b0;
        @(negedge aclk);
        total++;
        if (s_axis_tready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: got %b want 1", s_axis_tready);
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic test_full_packets;
        int w;
        logic [M_WIDTH-1:0] exp_d[2];
        exp_d[0] = 128'h00000004_00000003_00000002_00000001;
        exp_d[1] = 128'h00000008_00000007_00000006_00000005;
        got.delete();
        for (int b = 1; b <= 8; b++) begin
            send(lane_t'(b), 4'hF, b == 8, w);
            total++;
            if (w !== 1) begin
                bad++;
                $display("FAIL full_ready: beat %0d waited %0d cycles want 1", b, w);
            end
            if (b % 4 == 0) begin
                total++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_d[b/4-1] ||
                    m_axis_tkeep !== 16'hFFFF || m_axis_tlast !== (b == 8)) begin
                    bad++;
                    $display("FAIL full_beat%0d: v=%b d=%h k=%h l=%b want v=1 d=%h k=ffff l=%b",
                             b/4-1, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
                             exp_d[b/4-1], b == 8);
                end
            end
        end
        idle(3);
        total++;
        if (got.size() !== 2) begin
            bad++;
            $display("FAIL full_count: got %0d wide beats want 2", got.size());
        end
    endtask

    task automatic test_partial_flush;
        int w;
        got.delete();
        for (int b = 1; b <= 6; b++)
            send(lane_t'(32'hA0 + b), 4'hF, b == 6, w);
        total++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 128'h00000000_00000000_000000A6_000000A5 ||
            m_axis_tkeep !== 16'h00FF || m_axis_tlast !== 1'b1) begin
            bad++;
            $display("FAIL partial_flush: v=%b d=%h k=%h l=%b want v=1 d=..a6_000000a5 k=00ff l=1",
                     m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast);
        end
        idle(2);
        total++;
        if (got.size() !== 2 || got[0].d !== 128'h000000A4_000000A3_000000A2_000000A1 || got[0].l !== 1'b0) begin
            bad++;
            $display("FAIL partial_first: count=%0d d=%h want count=2 d=a4_a3_a2_a1 l=0",
                     got.size(), got.size() > 0 ? got[0].d : '0);
        end
    endtask

    task automatic test_lone_last;
        int w;
        got.delete();
        send(32'hC3, 4'h3, 1'b1, w);
        total++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 128'hC3 ||
            m_axis_tkeep !== 16'h0003 || m_axis_tlast !== 1'b1) begin
            bad++;
            $display("FAIL lone_last: v=%b d=%h k=%h l=%b want v=1 d=c3 k=0003 l=1",
                     m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast);
        end
        idle(2);
    endtask

    task automatic test_backpressure;
        int w;
        logic [M_WIDTH-1:0] exp0, exp1;
        exp0 = 128'h000000D4_000000D3_000000D2_000000D1;
        exp1 = 128'h000000D8_000000D7_000000D6_000000D5;
        got.delete();
        m_axis_tready = 1'b0;
        for (int b = 1; b <= 4; b++)
            send(lane_t'(32'hD0 + b), 4'hF, 1'b0, w);
        total++;
        if (m_axis_tvalid !== 1'b1 || s_axis_tready !== 1'b0) begin
            bad++;
            $display("FAIL bp_stall: v=%b rdy=%b want v=1 rdy=0", m_axis_tvalid, s_axis_tready);
        end
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'hD5;
        s_axis_tkeep  = 4'hF;
        s_axis_tlast  = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge aclk);
            total++;
            if (m_axis_tdata !== exp0 || s_axis_tready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold%0d: d=%h rdy=%b want d=%h rdy=0", c, m_axis_tdata, s_axis_tready, exp0);
            end
        end
        @(posedge aclk);
        #1;
        m_axis_tready = 1'b1;
        @(negedge aclk);
        total++;
        if (s_axis_tready !== 1'b1) begin
            bad++;
            $display("FAIL bp_resume: rdy=%b want 1", s_axis_tready);
        end
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
        for (int b = 6; b <= 8; b++)
            send(lane_t'(32'hD0 + b), 4'hF, b == 8, w);
        idle(3);
        total++;
        if (got.size() !== 2 || got[0].d !== exp0 || got[0].l !== 1'b0 ||
            got[1].d !== exp1 || got[1].l !== 1'b1) begin
            bad++;
            $display("FAIL bp_stream: count=%0d want 2 beats d0=%h d1=%h", got.size(), exp0, exp1);
        end
    endtask

    task automatic test_reset_mid;
        int w;
        got.delete();
        send(32'hE1, 4'hF, 1'b0, w);
        send(32'hE2, 4'hF, 1'b0, w);
        areset = 1'b1;
        @(posedge aclk);
        #1;
        areset = 1'b0;
        for (int b = 1; b <= 4; b++)
            send(lane_t'(32'hB0 + b), 4'hF, 1'b0, w);
        idle(3);
        total++;
        if (got.size() !== 1 || got[0].d !== 128'h000000B4_000000B3_000000B2_000000B1 ||
            got[0].k !== 16'hFFFF || got[0].l !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: count=%0d d=%h want count=1 d=b4_b3_b2_b1 k=ffff l=0",
                     got.size(), got.size() > 0 ? got[0].d : '0);
        end
    endtask

    task automatic test_random;
        int w;
        int cnt = 0;
        wide_t exp_q[$];
        logic [M_WIDTH-1:0] acc_d = '0;
        logic [KEEP_W-1:0]  acc_k = '0;
        lane_t d;
        lane_keep_t k;
        logic l;
        got.delete();
        rnd_on = 1'b1;
        fork
            while (rnd_on) begin
                @(posedge aclk);
                #1;
                m_axis_tready = 1'($urandom_range(0, 1));
            end
        join_none
        for (int b = 0; b < 1000; b++) begin
            if ($urandom_range(0, 1) == 0)
                idle(1);
            d = $urandom;
            k = 4'($urandom_range(0, 15));
            l = (b == 999) || ($urandom_range(0, 7) == 0);
            acc_d[cnt*32 +: 32] = d;
            acc_k[cnt*4 +: 4]   = k;
            if (cnt == 3 || l) begin
                exp_q.push_back('{d: acc_d, k: acc_k, l: l});
                acc_d = '0;
                acc_k = '0;
                cnt = 0;
            end else begin
                cnt++;
            end
            send(d, k, l, w);
        end
        rnd_on = 1'b0;
        @(posedge aclk);
        #2;
        m_axis_tready = 1'b1;
        idle(4);
        total++;
        if (got.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL rand_count: got %0d wide beats want %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            total++;
            if (got[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL rand_beat%0d: d=%h k=%h l=%b want d=%h k=%h l=%b", i,
                         got[i].d, got[i].k, got[i].l, exp_q[i].d, exp_q[i].k, exp_q[i].l);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_packets();
        test_partial_flush();
        test_lone_last();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
